// File: rtl/fetch_prefetch_queue.sv
// In-order instruction prefetch queue: issues up to DEPTH fetches, buffers responses, redirects on branch.
// Latency: response in cycle N presents inst_valid in cycle N+1; redirect refetches from taddr next cycle.
// Backpressure: issue stalls when allocated plus to-be-dropped entries reach DEPTH; imem_req/addr hold while gnt=0.
module fetch_prefetch_queue #(
    parameter int              AW       = 16,
    parameter int              DW       = 16,
    parameter logic [AW-1:0]   RESET_PC = 16'h3000,
    parameter int              DEPTH    = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable_fetch,
    input  logic                     br_taken,
    input  logic [AW-1:0]            taddr,
    output logic                     imem_req,
    output logic [AW-1:0]            imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [DW-1:0]            imem_rdata,
    output logic                     inst_valid,
    output logic [DW-1:0]            inst,
    output logic [AW-1:0]            pc,
    output logic [AW-1:0]            npc,
    input  logic                     inst_ready,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     resp_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    fetch_pc;
    logic [PW-1:0]    alloc_ptr;
    logic [PW-1:0]    fill_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    q_cnt;
    logic [CW-1:0]    pend_cnt;
    logic [CW-1:0]    drop_cnt;
    logic [DEPTH-1:0] filled;
    logic [AW-1:0]    pc_mem   [DEPTH];
    logic [DW-1:0]    data_mem [DEPTH];

    logic             acc;
    logic             pop;
    logic             rv_fill;
    logic             rv_drop;
    logic             rv_stray;
    logic [CW-1:0]    drop_next;

    // Entries still owed a response by memory count against capacity, so stale ones block issue too.
    assign imem_req   = reset && enable_fetch && ((q_cnt + drop_cnt) < CW'(DEPTH));
    assign imem_addr  = fetch_pc;
    assign acc        = imem_req && imem_gnt;

    assign rv_drop    = imem_rvalid && (drop_cnt != '0);
    assign rv_fill    = imem_rvalid && (drop_cnt == '0) && (pend_cnt != '0);
    assign rv_stray   = imem_rvalid && (drop_cnt == '0) && (pend_cnt == '0);

    assign inst_valid = (q_cnt != '0) && filled[rd_ptr];
    assign inst       = data_mem[rd_ptr];
    assign pc         = pc_mem[rd_ptr];
    assign npc        = pc_mem[rd_ptr] + 1'b1;
    assign pop        = inst_valid && inst_ready;
    assign q_count    = q_cnt;

    // On redirect every unanswered request becomes stale, including one accepted this very cycle.
    assign drop_next  = pend_cnt + drop_cnt + CW'(acc) - CW'(rv_fill || rv_drop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc  <= RESET_PC;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            q_cnt     <= '0;
            pend_cnt  <= '0;
            drop_cnt  <= '0;
            filled    <= '0;
            resp_err  <= 1'b0;
        end else begin
            if (rv_stray) begin
                resp_err <= 1'b1;
            end
            if (br_taken) begin
                fetch_pc  <= taddr;
                alloc_ptr <= '0;
                fill_ptr  <= '0;
                rd_ptr    <= '0;
                q_cnt     <= '0;
                pend_cnt  <= '0;
                drop_cnt  <= drop_next;
                filled    <= '0;
            end else begin
                if (acc) begin
                    alloc_ptr         <= alloc_ptr + 1'b1;
                    fetch_pc          <= fetch_pc + 1'b1;
                    filled[alloc_ptr] <= 1'b0;
                end
                if (rv_fill) begin
                    fill_ptr          <= fill_ptr + 1'b1;
                    filled[fill_ptr]  <= 1'b1;
                end
                if (rv_drop) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                q_cnt    <= q_cnt + CW'(acc) - CW'(pop);
                pend_cnt <= pend_cnt + CW'(acc) - CW'(rv_fill);
            end
        end
    end

    // Payload storage needs no reset: the filled flags and counters qualify every read.
    always_ff @(posedge clock) begin
        if (acc && !br_taken) begin
            pc_mem[alloc_ptr] <= fetch_pc;
        end
        if (rv_fill && !br_taken) begin
            data_mem[fill_ptr] <= imem_rdata;
        end
    end

endmodule
